imem_fetch_ctrl: RTL

- Parametrised instruction memory with a request/response fetch interface and configurable read latency.
- Includes a program-load write port for the boot loader and debug loader.
- Sits between the fetch stage (PC generator) and the instruction decode stage. Replaces the plain combinational word-indexed ROM.
- Reports alignment and range faults so the core can raise instruction-fetch exceptions.

---
 rtl/imem_fetch_if.sv | 55 +++++
 rtl/imem_fetch_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_if.sv
// ---------------------------------------------------------------------------
// imem_fetch_if
//
// Bundles the fetch request/response handshake, the program-load port and
// the busy indication of imem_fetch_ctrl.
//
//   req_valid   master->slave  fetch request present
//   req_ready   slave->master  request can be accepted this cycle
//   req_addr    master->slave  byte address of the instruction
//   rsp_valid   slave->master  response available
//   rsp_ready   master->slave  consumer accepts the response
//   rsp_instr   slave->master  fetched instruction word
//   rsp_fault   slave->master  00 ok, 01 misaligned, 10 out of range,
//                              11 parity error
//   load_en     master->slave  write one word into the array
//   load_addr   master->slave  byte address of the load
//   load_data   master->slave  word to write
//   busy        slave->master  a request is outstanding
//   inject_par_err (only with IMEM_PARITY_EN) inverts the stored parity bit
//                              of a load, used to exercise the parity check
// ---------------------------------------------------------------------------
interface imem_fetch_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_instr;
  logic [1:0]        rsp_fault;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              busy;
`ifdef IMEM_PARITY_EN
  logic              inject_par_err;
`endif

  modport master (
    output req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
`ifdef IMEM_PARITY_EN
    output inject_par_err,
`endif
    input  req_ready, rsp_valid, rsp_instr, rsp_fault, busy
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
`ifdef IMEM_PARITY_EN
    input  inject_par_err,
`endif
    output req_ready, rsp_valid, rsp_instr, rsp_fault, busy
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Instruction memory with a request/response fetch interface, a configurable
// read latency of 1..4 cycles and a program-load write port. Alignment and
// range faults are reported with a NOP instruction so the core can raise an
// instruction-fetch exception.
//
// Ports:
//   clk    single clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    imem_fetch_if.slave (fetch request/response, load port, busy)
//
// Parameters: DEPTH (words, power of two 16..65536), ADDR_W (byte address
// width), LATENCY (1..4, accept cycle to rsp_valid), NOP_INSTR (word returned
// on a fault).
//
// Optional feature: define IMEM_PARITY_EN to store an even-parity bit per
// word, check it on the response read (fault 11) and add inject_par_err.
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter int          DEPTH     = 1024,
  parameter int          ADDR_W    = 32,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  imem_fetch_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 2;
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = 33;
  localparam logic [1:0] F_PAR = 2'b11;
`else
  localparam int MEM_W = 32;
`endif
  localparam logic [1:0] F_OK    = 2'b00;
  localparam logic [1:0] F_MIS   = 2'b01;
  localparam logic [1:0] F_RANGE = 2'b10;

  generate
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("imem_fetch_ctrl: LATENCY must be in 1..4");
    end
    if (DEPTH < 16 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("imem_fetch_ctrl: DEPTH must be a power of two in 16..65536");
    end
    if (ADDR_W < IDX_W + 3) begin : g_bad_addr_w
      $error("imem_fetch_ctrl: ADDR_W too small for DEPTH");
    end
  endgenerate

  // Misaligned wins over out of range.
  function automatic logic [1:0] addr_fault(input logic [ADDR_W-1:0] a);
    if (a[1:0] != 2'b00)
      addr_fault = F_MIS;
    else if (|a[ADDR_W-1:IDX_W+2])
      addr_fault = F_RANGE;
    else
      addr_fault = F_OK;
  endfunction

  function automatic logic even_par(input logic [31:0] w);
    even_par = ^w;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_p0;
  logic [31:0]        rsp_instr_p1;
  logic [1:0]         rsp_fault_p1;
  logic               req_ready_c;
  logic               accept;
  logic               enter_resp;
  logic [ADDR_W-1:0]  rd_addr;
  logic [MEM_W-1:0]   rd_word;
  logic [1:0]         rd_fault;
  logic               ld_ok;
  logic [MEM_W-1:0]   ld_word;

  logic [MEM_W-1:0]   mem [DEPTH];

  assign accept = bus.req_valid && req_ready_c;

  // With LATENCY==1 the accept edge is also the RESP-entry edge, so the read
  // has to use the live request address rather than the captured one.
  assign rd_addr    = (state == S_IDLE) ? bus.req_addr : addr_p0;
  assign enter_resp = (state != S_RESP) && (state_nxt == S_RESP);
  assign rd_word    = mem[rd_addr[IDX_W+1:2]];

  always_comb begin
    rd_fault = addr_fault(rd_addr);
`ifdef IMEM_PARITY_EN
    if (rd_fault == F_OK && even_par(rd_word[31:0]) != rd_word[32])
      rd_fault = F_PAR;
`endif
  end

  // Load port: faulty addresses are dropped without any indication.
  assign ld_ok = bus.load_en && (addr_fault(bus.load_addr) == F_OK);
`ifdef IMEM_PARITY_EN
  assign ld_word = {even_par(bus.load_data) ^ bus.inject_par_err, bus.load_data};
`else
  assign ld_word = bus.load_data;
`endif

  // Array write; the response register samples rd_word on the same edge,
  // so a same-edge load to the fetched word returns the old contents.
  always_ff @(posedge clk) begin
    if (ld_ok)
      mem[bus.load_addr[IDX_W+1:2]] <= ld_word;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == CNT_W'(1)) state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready_c   = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.busy      = 1'b1;
    unique case (state)
      S_IDLE: begin
        req_ready_c = !bus.load_en;
        bus.busy    = 1'b0;
      end
      S_WAIT: ;
      S_RESP: bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Stage p0: request capture and latency countdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      addr_p0 <= '0;
    end else if (accept) begin
      cnt     <= CNT_W'(LATENCY - 1);
      addr_p0 <= bus.req_addr;
    end else if (state == S_WAIT) begin
      cnt     <= cnt - CNT_W'(1);
    end
  end

  // Stage p1: response register, loaded only on RESP entry so it holds
  // steady through any rsp_ready stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_instr_p1 <= '0;
      rsp_fault_p1 <= F_OK;
    end else if (enter_resp) begin
      rsp_fault_p1 <= rd_fault;
      rsp_instr_p1 <= (rd_fault == F_OK) ? rd_word[31:0] : NOP_INSTR;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_instr = rsp_instr_p1;
  assign bus.rsp_fault = rsp_fault_p1;

endmodule
